// File: rtl/pattern_event_monitor.sv
// Windowed event-rate monitor for the output of a 1010 Moore sequence detector.
// Build option EDGE_DETECT_EN: count only rising edges of det_in instead of every high cycle.
module pattern_event_monitor #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             det_in,
    input  logic             en,
    input  logic             clr,
    input  logic [WIN_W-1:0] win_len,
    input  logic [WIN_W-1:0] thresh,
    output logic [CNT_W-1:0] evt_count,
    output logic [WIN_W-1:0] win_count,
    output logic             win_done,
    output logic             alarm,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ALARM = 2'd2
    } state_t;

    localparam logic [WIN_W:0] TIMER_ONE = {{WIN_W{1'b0}}, 1'b1};

    state_t           r_state, w_state_nxt;
    logic [WIN_W:0]   r_timer, w_timer_nxt;
    logic [CNT_W-1:0] r_evt_count, w_evt_nxt, w_evt_inc;
    logic [WIN_W-1:0] r_win_count, w_win_nxt, w_win_inc;
    logic             r_win_done, w_done_nxt;
    logic             r_alarm, w_alarm_nxt;
    logic             w_event;
    logic             w_hit;
    logic [WIN_W:0]   w_reload;

`ifdef EDGE_DETECT_EN
    logic r_det_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_det_prev <= 1'b0;
        else        r_det_prev <= det_in;
    end

    assign w_event = det_in & ~r_det_prev;
`else
    assign w_event = det_in;
`endif

    // A zero window length stands for a full 2^WIN_W-cycle window.
    assign w_reload  = (win_len == '0) ? {1'b1, {WIN_W{1'b0}}} : {1'b0, win_len};
    assign w_evt_inc = (w_event && r_evt_count != {CNT_W{1'b1}}) ? r_evt_count + 1'b1 : r_evt_count;
    assign w_win_inc = (w_event && r_win_count != {WIN_W{1'b1}}) ? r_win_count + 1'b1 : r_win_count;
    assign w_hit     = (thresh != '0) && (w_win_inc >= thresh);

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_evt_nxt   = r_evt_count;
        w_win_nxt   = r_win_count;
        w_done_nxt  = 1'b0;
        w_alarm_nxt = r_alarm;

        if (clr) begin
            w_evt_nxt   = '0;
            w_win_nxt   = '0;
            w_alarm_nxt = 1'b0;
            if (en) begin
                w_state_nxt = RUN;
                w_timer_nxt = w_reload;
            end else begin
                w_state_nxt = IDLE;
                w_timer_nxt = '0;
            end
        end else if (!en) begin
            w_state_nxt = IDLE;
            w_timer_nxt = '0;
            w_win_nxt   = '0;
            w_alarm_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = RUN;
                    w_timer_nxt = w_reload;
                    w_win_nxt   = '0;
                    w_alarm_nxt = 1'b0;
                end
                RUN, ALARM: begin
                    w_evt_nxt   = w_evt_inc;
                    // alarm trails the ALARM state entry by one cycle
                    w_alarm_nxt = (r_state == ALARM);
                    if (r_state == RUN && w_hit) w_state_nxt = ALARM;
                    if (r_timer <= TIMER_ONE) begin
                        w_done_nxt  = 1'b1;
                        w_win_nxt   = '0;
                        w_timer_nxt = w_reload;
                    end else begin
                        w_win_nxt   = w_win_inc;
                        w_timer_nxt = r_timer - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_timer_nxt = '0;
                    w_win_nxt   = '0;
                    w_alarm_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_evt_count <= '0;
            r_win_count <= '0;
            r_win_done  <= 1'b0;
            r_alarm     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_evt_count <= w_evt_nxt;
            r_win_count <= w_win_nxt;
            r_win_done  <= w_done_nxt;
            r_alarm     <= w_alarm_nxt;
        end
    end

    assign evt_count   = r_evt_count;
    assign win_count   = r_win_count;
    assign win_done    = r_win_done;
    assign alarm       = r_alarm;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pattern_event_monitor.sv
// Directed bench for pattern_event_monitor: default build plus a CNT_W=4 copy for saturation.
module tb_pattern_event_monitor;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_ALARM = 2'd2;
`ifdef EDGE_DETECT_EN
    localparam int EDGE = 1;
`else
    localparam int EDGE = 0;
`endif

    logic        clk;
    logic        reset;
    logic        det_in;
    logic        en;
    logic        clr;
    logic [7:0]  win_len;
    logic [7:0]  thresh;
    logic [15:0] evt_count;
    logic [7:0]  win_count;
    logic        win_done;
    logic        alarm;
    logic [1:0]  dbg_state;
    logic [3:0]  s_evt_count;
    logic [7:0]  s_win_count;
    logic        s_win_done;
    logic        s_alarm;
    logic [1:0]  s_dbg_state;

    int vec_count = 0;
    int err_count = 0;
    int exp_evt;

    pattern_event_monitor dut (
        .clk(clk), .reset(reset), .det_in(det_in), .en(en), .clr(clr),
        .win_len(win_len), .thresh(thresh), .evt_count(evt_count),
        .win_count(win_count), .win_done(win_done), .alarm(alarm),
        .o_dbg_state(dbg_state)
    );

    pattern_event_monitor #(.CNT_W(4), .WIN_W(8)) dut_s (
        .clk(clk), .reset(reset), .det_in(det_in), .en(en), .clr(clr),
        .win_len(win_len), .thresh(thresh), .evt_count(s_evt_count),
        .win_count(s_win_count), .win_done(s_win_done), .alarm(s_alarm),
        .o_dbg_state(s_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        det_in = 1'b1;
        tick();
        det_in = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b1; clr = 1'b1; det_in = 1'b1;
        win_len = 8'd10; thresh = 8'd2;
        tick(); tick();
        vec_count++;
        if (dbg_state !== S_IDLE) begin err_count++; $display("FAIL reset_state got %0d want %0d", dbg_state, S_IDLE); end
        vec_count++;
        if (evt_count !== 16'd0) begin err_count++; $display("FAIL reset_evt got %0d want 0", evt_count); end
        vec_count++;
        if (win_count !== 8'd0) begin err_count++; $display("FAIL reset_win got %0d want 0", win_count); end
        vec_count++;
        if (win_done !== 1'b0 || alarm !== 1'b0) begin err_count++; $display("FAIL reset_flags got done=%b alarm=%b want 0 0", win_done, alarm); end
        vec_count++;
        if (s_dbg_state !== S_IDLE || s_evt_count !== 4'd0) begin err_count++; $display("FAIL reset_small got st=%0d evt=%0d want 0 0", s_dbg_state, s_evt_count); end
        clr = 1'b0; en = 1'b0; det_in = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_alarm();
        en = 1'b1; win_len = 8'd10; thresh = 8'd2;
        tick();
        vec_count++;
        if (dbg_state !== S_RUN || win_count !== 8'd0) begin err_count++; $display("FAIL alarm_start got st=%0d win=%0d want 1 0", dbg_state, win_count); end
        det_in = 1'b1; tick(); det_in = 1'b0;
        vec_count++;
        if (win_count !== 8'd1) begin err_count++; $display("FAIL alarm_first_evt got %0d want 1", win_count); end
        tick(); tick(); tick();
        det_in = 1'b1; tick(); det_in = 1'b0;
        vec_count++;
        if (win_count !== 8'd2 || dbg_state !== S_ALARM) begin err_count++; $display("FAIL alarm_second_evt got win=%0d st=%0d want 2 2", win_count, dbg_state); end
        vec_count++;
        if (alarm !== 1'b0) begin err_count++; $display("FAIL alarm_latency_early got %b want 0", alarm); end
        tick();
        vec_count++;
        if (alarm !== 1'b1 || evt_count !== 16'd2) begin err_count++; $display("FAIL alarm_assert got alarm=%b evt=%0d want 1 2", alarm, evt_count); end
        for (int i = 0; i < 3; i++) begin
            tick();
            vec_count++;
            if (win_done !== 1'b0) begin err_count++; $display("FAIL alarm_no_done[%0d] got %b want 0", i, win_done); end
        end
        tick();
        vec_count++;
        if (win_done !== 1'b1 || win_count !== 8'd0 || alarm !== 1'b1) begin
            err_count++;
            $display("FAIL alarm_window_end got done=%b win=%0d alarm=%b want 1 0 1", win_done, win_count, alarm);
        end
    endtask

    task automatic test_clr_in_alarm();
        clr = 1'b1; det_in = 1'b1;
        tick();
        clr = 1'b0; det_in = 1'b0;
        vec_count++;
        if (alarm !== 1'b0 || evt_count !== 16'd0 || win_count !== 8'd0 || dbg_state !== S_RUN) begin
            err_count++;
            $display("FAIL clr_alarm got alarm=%b evt=%0d win=%0d st=%0d want 0 0 0 1", alarm, evt_count, win_count, dbg_state);
        end
    endtask

    task automatic test_window();
        en = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        vec_count++;
        if (dbg_state !== S_IDLE || evt_count !== 16'd0 || win_count !== 8'd0 || alarm !== 1'b0) begin
            err_count++;
            $display("FAIL clr_en_low got st=%0d evt=%0d win=%0d alarm=%b want 0 0 0 0", dbg_state, evt_count, win_count, alarm);
        end
        en = 1'b1; win_len = 8'd4; thresh = 8'd0;
        tick();
        for (int w = 0; w < 3; w++) begin
            for (int c = 0; c < 3; c++) begin
                tick();
                vec_count++;
                if (win_done !== 1'b0) begin err_count++; $display("FAIL window_mid[%0d.%0d] got done=%b want 0", w, c, win_done); end
            end
            det_in = 1'b1; tick(); det_in = 1'b0;
            vec_count++;
            if (win_done !== 1'b1 || win_count !== 8'd0 || evt_count !== 16'(w + 1) || alarm !== 1'b0) begin
                err_count++;
                $display("FAIL window_end[%0d] got done=%b win=%0d evt=%0d alarm=%b want 1 0 %0d 0", w, win_done, win_count, evt_count, alarm, w + 1);
            end
        end
        // Shorter length applied mid-window only takes effect at the next reload.
        win_len = 8'd2;
        for (int c = 0; c < 3; c++) begin
            tick();
            vec_count++;
            if (win_done !== 1'b0) begin err_count++; $display("FAIL winlen_hold[%0d] got done=%b want 0", c, win_done); end
        end
        tick();
        vec_count++;
        if (win_done !== 1'b1) begin err_count++; $display("FAIL winlen_old_end got done=%b want 1", win_done); end
        tick();
        vec_count++;
        if (win_done !== 1'b0) begin err_count++; $display("FAIL winlen_new_mid got done=%b want 0", win_done); end
        tick();
        vec_count++;
        if (win_done !== 1'b1) begin err_count++; $display("FAIL winlen_new_end got done=%b want 1", win_done); end
    endtask

    task automatic test_hold_high();
        en = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0; en = 1'b1; win_len = 8'd0; thresh = 8'd0;
        tick();
        det_in = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        det_in = 1'b0;
        tick();
        exp_evt = (EDGE != 0) ? 1 : 5;
        vec_count++;
        if (evt_count !== 16'(exp_evt)) begin err_count++; $display("FAIL hold_high got %0d want %0d", evt_count, exp_evt); end
        vec_count++;
        if (s_evt_count !== 4'(exp_evt)) begin err_count++; $display("FAIL hold_high_small got %0d want %0d", s_evt_count, exp_evt); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 20; i++) pulse();
        exp_evt = exp_evt + 20;
        vec_count++;
        if (s_evt_count !== 4'd15) begin err_count++; $display("FAIL sat_reach got %0d want 15", s_evt_count); end
        vec_count++;
        if (evt_count !== 16'(exp_evt)) begin err_count++; $display("FAIL sat_wide got %0d want %0d", evt_count, exp_evt); end
        for (int i = 0; i < 3; i++) pulse();
        exp_evt = exp_evt + 3;
        vec_count++;
        if (s_evt_count !== 4'd15) begin err_count++; $display("FAIL sat_hold got %0d want 15", s_evt_count); end
        vec_count++;
        if (evt_count !== 16'(exp_evt)) begin err_count++; $display("FAIL sat_wide_more got %0d want %0d", evt_count, exp_evt); end
    endtask

    task automatic test_en_drop();
        en = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0; en = 1'b1; win_len = 8'd20; thresh = 8'd3;
        tick();
        for (int i = 0; i < 6; i++) pulse();
        vec_count++;
        if (evt_count !== 16'd6 || win_count !== 8'd6 || alarm !== 1'b1 || dbg_state !== S_ALARM) begin
            err_count++;
            $display("FAIL en_drop_pre got evt=%0d win=%0d alarm=%b st=%0d want 6 6 1 2", evt_count, win_count, alarm, dbg_state);
        end
        en = 1'b0;
        tick();
        vec_count++;
        if (dbg_state !== S_IDLE || alarm !== 1'b0 || win_count !== 8'd0 || evt_count !== 16'd6) begin
            err_count++;
            $display("FAIL en_drop got st=%0d alarm=%b win=%0d evt=%0d want 0 0 0 6", dbg_state, alarm, win_count, evt_count);
        end
        for (int i = 0; i < 3; i++) pulse();
        vec_count++;
        if (evt_count !== 16'd6 || dbg_state !== S_IDLE || win_done !== 1'b0) begin
            err_count++;
            $display("FAIL idle_ignore got evt=%0d st=%0d done=%b want 6 0 0", evt_count, dbg_state, win_done);
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1; win_len = 8'd10; thresh = 8'd0;
        tick();
        pulse();
        vec_count++;
        if (evt_count !== 16'd7) begin err_count++; $display("FAIL async_pre got %0d want 7", evt_count); end
        #2;
        reset = 1'b0; det_in = 1'b1;
        #1;
        vec_count++;
        if (dbg_state !== S_IDLE || evt_count !== 16'd0 || alarm !== 1'b0) begin
            err_count++;
            $display("FAIL async_reset got st=%0d evt=%0d alarm=%b want 0 0 0", dbg_state, evt_count, alarm);
        end
        tick();
        reset = 1'b1;
        tick();
        vec_count++;
        if (dbg_state !== S_RUN || evt_count !== 16'd0) begin
            err_count++;
            $display("FAIL post_reset_first got st=%0d evt=%0d want 1 0", dbg_state, evt_count);
        end
        tick();
        exp_evt = (EDGE != 0) ? 0 : 1;
        vec_count++;
        if (evt_count !== 16'(exp_evt)) begin err_count++; $display("FAIL post_reset_high got %0d want %0d", evt_count, exp_evt); end
        det_in = 1'b0;
    endtask

    initial begin
        reset = 1'b0; det_in = 1'b0; en = 1'b0; clr = 1'b0;
        win_len = '0; thresh = '0; exp_evt = 0;
        test_reset();
        test_alarm();
        test_clr_in_alarm();
        test_window();
        test_hold_high();
        test_saturate();
        test_en_drop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
